// File: rtl/cart2polar_cordic_if.sv
// rtl/cart2polar_cordic_if.sv - start/operand and result bundle for cart2polar_cordic
interface cart2polar_cordic_if;
    logic              Start_Pulse;
    logic signed [8:0] InpX;
    logic signed [8:0] InpY;
    logic        [7:0] Inp_The;
    logic        [8:0] OTPX;
    logic signed [8:0] OTPY;
    logic        [7:0] Theta_Pre;

    modport master (
        output Start_Pulse, InpX, InpY, Inp_The,
        input  OTPX, OTPY, Theta_Pre
    );

    modport slave (
        input  Start_Pulse, InpX, InpY, Inp_The,
        output OTPX, OTPY, Theta_Pre
    );
endinterface

// File: rtl/cart2polar_cordic.sv
// rtl/cart2polar_cordic.sv - iterative 9-bit vectoring CORDIC, Cartesian to polar
// Define CORDIC_GAIN_COMP_EN to scale the magnitude by the inverse CORDIC gain.
module cart2polar_cordic (
    input  logic               CLK,
    input  logic               RST_N,
    cart2polar_cordic_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PRE, ITER, OUT} state_t;

    state_t             state;
    logic               rst_released;
    logic signed [11:0] x;
    logic signed [11:0] y;
    logic        [7:0]  z;
    logic        [2:0]  iter;
    logic               zero_vec;

    logic signed [11:0] x_shift;
    logic signed [11:0] y_shift;
    logic        [7:0]  atan_step;
    logic signed [21:0] mag;
    logic        [8:0]  mag_sat;
    logic signed [8:0]  y_sat;

    assign x_shift = x >>> iter;
    assign y_shift = y >>> iter;

    always_comb begin
        atan_step = 8'd0;
        case (iter)
            3'd0: atan_step = 8'd32;
            3'd1: atan_step = 8'd19;
            3'd2: atan_step = 8'd10;
            3'd3: atan_step = 8'd5;
            3'd4: atan_step = 8'd3;
            3'd5: atan_step = 8'd1;
            3'd6: atan_step = 8'd1;
            default: atan_step = 8'd0;
        endcase
    end

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [21:0] x_wide;
    assign x_wide = {{10{x[11]}}, x};
    // Shifted terms are summed at full precision and truncated once: X * 311 / 512.
    assign mag = ((x_wide <<< 8) + (x_wide <<< 6) - (x_wide <<< 3) - x_wide) >>> 9;
`else
    assign mag = {{10{x[11]}}, x};
`endif

    always_comb begin
        mag_sat = mag[8:0];
        if (mag < 22'sd0) begin
            mag_sat = 9'd0;
        end else if (mag > 22'sd255) begin
            mag_sat = 9'd255;
        end
    end

    always_comb begin
        y_sat = y[8:0];
        if (y > 12'sd255) begin
            y_sat = 9'sd255;
        end else if (y < -12'sd256) begin
            y_sat = -9'sd256;
        end
    end

    // rst_released holds off start acceptance until the first edge after reset release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            rst_released  <= 1'b0;
            x             <= '0;
            y             <= '0;
            z             <= '0;
            iter          <= '0;
            zero_vec      <= 1'b0;
            bus.OTPX      <= '0;
            bus.OTPY      <= '0;
            bus.Theta_Pre <= '0;
        end else begin
            rst_released <= 1'b1;
            if (rst_released && bus.Start_Pulse) begin
                x        <= {{3{bus.InpX[8]}}, bus.InpX};
                y        <= {{3{bus.InpY[8]}}, bus.InpY};
                z        <= bus.Inp_The;
                iter     <= '0;
                zero_vec <= (bus.InpX == 9'sd0) && (bus.InpY == 9'sd0);
                state    <= PRE;
            end else begin
                case (state)
                    PRE: begin
                        if (x < 12'sd0) begin
                            x <= -x;
                            y <= -y;
                            z <= z + 8'd128;
                        end
                        iter  <= '0;
                        state <= ITER;
                    end
                    ITER: begin
                        // A zero vector has no direction; keep the angle at the offset.
                        if (!y[11]) begin
                            x <= x + y_shift;
                            y <= y - x_shift;
                            if (!zero_vec) z <= z + atan_step;
                        end else begin
                            x <= x - y_shift;
                            y <= y + x_shift;
                            if (!zero_vec) z <= z - atan_step;
                        end
                        iter <= iter + 3'd1;
                        if (iter == 3'd7) state <= OUT;
                    end
                    OUT: begin
                        bus.OTPX      <= mag_sat;
                        bus.OTPY      <= y_sat;
                        bus.Theta_Pre <= z;
                        state         <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cart2polar_cordic.sv
// tb/tb_cart2polar_cordic.sv - scoreboard bench for cart2polar_cordic
module tb_cart2polar_cordic;
    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    cart2polar_cordic_if bus();

    cart2polar_cordic dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

`ifdef CORDIC_GAIN_COMP_EN
    localparam bit COMP = 1'b1;
`else
    localparam bit COMP = 1'b0;
`endif

    typedef struct {
        int    due;
        int    x_exp;
        int    x_tol;
        int    y_tol;
        int    th_exp;
        int    th_tol;
        int    mono;
        string name;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         prev_th = -1;
    bit         hold_valid = 1'b0;
    logic [8:0] hold_x;
    logic [8:0] hold_y;
    logic [7:0] hold_th;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int ang_diff(input int a, input int b);
        logic [7:0] t;
        t = 8'(a - b);
        return (t >= 8'd128) ? int'(t) - 256 : int'(t);
    endfunction

    task automatic check(input string nm, input int act, input int exp, input int tol);
        n_checks++;
        if ((act - exp > tol) || (exp - act > tol)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d (cycle %0d)", nm, act, exp, tol, cyc);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (!RST_N) begin
            check("reset_otpx", int'(bus.OTPX), 0, 0);
            check("reset_otpy", int'(bus.OTPY), 0, 0);
            check("reset_theta", int'(bus.Theta_Pre), 0, 0);
            hold_x     = 9'd0;
            hold_y     = 9'd0;
            hold_th    = 8'd0;
            hold_valid = 1'b1;
        end else if (sb_q.size() > 0 && cyc == sb_q[0].due) begin
            e = sb_q.pop_front();
            check({e.name, "_otpx"}, int'(bus.OTPX), e.x_exp, e.x_tol);
            check({e.name, "_otpy"}, int'(bus.OTPY), 0, e.y_tol);
            check({e.name, "_theta"}, e.th_exp + ang_diff(int'(bus.Theta_Pre), e.th_exp), e.th_exp, e.th_tol);
            if (e.mono == 2) begin
                n_checks++;
                if (int'(bus.Theta_Pre) > prev_th) begin
                    n_fail++;
                    $display("FAIL %s_monotonic: got %0d, required <= %0d", e.name, bus.Theta_Pre, prev_th);
                end
            end
            if (e.mono != 0) prev_th = int'(bus.Theta_Pre);
            hold_x  = bus.OTPX;
            hold_y  = bus.OTPY;
            hold_th = bus.Theta_Pre;
        end else if (hold_valid) begin
            n_checks++;
            if (bus.OTPX !== hold_x || bus.OTPY !== hold_y || bus.Theta_Pre !== hold_th) begin
                n_fail++;
                $display("FAIL hold: got %0d/%0d/%0d, required unchanged %0d/%0d/%0d (cycle %0d)",
                         bus.OTPX, $signed(bus.OTPY), bus.Theta_Pre,
                         hold_x, $signed(hold_y), hold_th, cyc);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Start is raised just after an edge, so it is sampled on the following edge;
    // outputs land 10 edges after that, i.e. 11 counts after the issue value.
    task automatic issue(input int ix, input int iy, input int ith, input bit push,
                         input int xe, input int xt, input int yt,
                         input int the, input int tht, input int mono, input string nm);
        exp_t e;
        @(posedge CLK);
        #1;
        bus.InpX        = 9'(ix);
        bus.InpY        = 9'(iy);
        bus.Inp_The     = 8'(ith);
        bus.Start_Pulse = 1'b1;
        if (push) begin
            e.due    = cyc + 11;
            e.x_exp  = xe;
            e.x_tol  = xt;
            e.y_tol  = yt;
            e.th_exp = the;
            e.th_tol = tht;
            e.mono   = mono;
            e.name   = nm;
            sb_q.push_back(e);
        end
        @(posedge CLK);
        #1;
        bus.Start_Pulse = 1'b0;
    endtask

    // Sweep (0,100) -> (100,0): hand-computed atan2 in binary angle, |v| and 1.6468*|v|.
    int sweep_th[11]  = '{64, 59, 54, 48, 40, 32, 24, 16, 10, 5, 0};
    int sweep_mag[11] = '{100, 91, 82, 76, 72, 71, 72, 76, 82, 91, 100};
    int sweep_raw[11] = '{165, 149, 136, 125, 119, 116, 119, 125, 136, 149, 165};

    initial begin : stimulus
        int m100;
        int t100;
        m100 = COMP ? 100 : 165;
        t100 = COMP ? 2 : 3;
        bus.Start_Pulse = 1'b0;
        bus.InpX        = '0;
        bus.InpY        = '0;
        bus.Inp_The     = '0;
        RST_N = 1'b1;
        #1 RST_N = 1'b0;
        wait_cycles(3);
        RST_N = 1'b1;
        wait_cycles(2);

        issue(0, 100, 0, 1, m100, t100, 2, 64, 2, 0, "up");
        wait_cycles(10);
        issue(-100, 0, 0, 1, m100, t100, 2, 128, 2, 0, "left");
        wait_cycles(10);
        issue(0, -100, 0, 1, m100, t100, 2, 192, 2, 0, "down");
        wait_cycles(10);
        issue(0, 100, 250, 1, m100, t100, 2, 58, 2, 0, "wrap");
        wait_cycles(10);
        issue(0, 0, 77, 1, 0, 0, 0, 77, 0, 0, "zero");
        wait_cycles(10);
        issue(-256, -256, 0, 1, 255, 0, 5, 160, 2, 0, "sat");
        wait_cycles(10);

        for (int k = 0; k < 11; k++) begin
            issue(10 * k, 100 - 10 * k, 0, 1,
                  COMP ? sweep_mag[k] : sweep_raw[k], COMP ? 2 : 4, 2,
                  sweep_th[k], 2, (k == 0) ? 1 : 2, $sformatf("sweep%0d", k));
            wait_cycles(18);
        end

        // First conversion is aborted 5 cycles in; only the second may reach the outputs.
        issue(0, 100, 0, 0, 0, 0, 0, 0, 0, 0, "aborted");
        wait_cycles(3);
        issue(-100, 0, 0, 1, m100, t100, 2, 128, 2, 0, "restart");
        wait_cycles(14);

        issue(0, 100, 0, 0, 0, 0, 0, 0, 0, 0, "reset_victim");
        wait_cycles(3);
        RST_N = 1'b0;
        wait_cycles(2);
        // A start covering only the first edge after release must be ignored.
        RST_N           = 1'b1;
        bus.InpX        = 9'sd50;
        bus.InpY        = 9'sd50;
        bus.Start_Pulse = 1'b1;
        wait_cycles(1);
        bus.Start_Pulse = 1'b0;
        wait_cycles(15);

        RST_N = 1'b0;
        wait_cycles(1);
        RST_N = 1'b1;
        issue(50, 50, 0, 1, COMP ? 71 : 116, COMP ? 2 : 4, 2, 32, 2, 0, "after_release");

        for (int w = 0; w < 50 && sb_q.size() > 0; w++) wait_cycles(1);
        while (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_missing: got no result, required one by cycle %0d", sb_q[0].name, sb_q[0].due);
            void'(sb_q.pop_front());
        end
        wait_cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end
endmodule
